isquare_seq: RTL and testbench
==============================

ISQUARE_SEQ -- requirements
Module: isquare_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand (root) width in bits; legal range 2..16.
REQ-002 The block SHALL have parameter TC_MODE, default 0: 0 = operand unsigned, 1 = operand two's complement.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 x  input  WIDTH  operand to be squared.
REQ-006 in_valid  input  1  x is valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 sq  output  2*WIDTH  square of the accepted operand's magnitude, unsigned.
REQ-009 out_valid  output  1  sq holds a completed result.
REQ-010 out_ready  input  1  consumer accepts sq this cycle.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, CALC and DONE, with one-hot or binary encoding taken from the shared include file.
REQ-012 in_ready SHALL equal (state == IDLE), driven from registered state only; out_valid SHALL equal (state == DONE).
REQ-013 Accept: an edge with in_valid && in_ready SHALL register the operand's magnitude, clear the accumulator and iteration counter, and move IDLE -> CALC.
REQ-014 Magnitude: with TC_MODE=0 it SHALL be x; with TC_MODE=1 and x[WIDTH-1]=1 it SHALL be (~x + 1) as a WIDTH-bit unsigned value, so the most negative input maps to 2^(WIDTH-1).
REQ-015 CALC SHALL perform one shift-add step per edge: if multiplier LSB = 1, add the 2*WIDTH-bit multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; increment the counter.
REQ-016 After exactly WIDTH CALC edges, the block SHALL load sq with the accumulator (including the final step's addition) and move CALC -> DONE. out_valid is therefore first high after the WIDTH-th edge following the accepting edge, for example after 4 edges when WIDTH=4.
REQ-017 The accumulator SHALL be 2*WIDTH bits wide; no overflow can occur, and the maximum result is (2^WIDTH - 1)^2.
REQ-018 In DONE, sq and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL move DONE -> IDLE.
REQ-019 The block SHALL ignore x and in_valid in CALC and DONE, with no queuing. A new operand SHALL be accepted no earlier than the cycle after the out handshake.
REQ-020 sq SHALL change only on the CALC -> DONE edge and on reset; it SHALL retain the last result while in IDLE.
REQ-021 out_ready asserted outside DONE SHALL have no effect.
REQ-022 Zero operand SHALL run the full WIDTH-cycle sequence and yield sq = 0; the block SHALL have no early-termination path.

Reset
REQ-023 reset_n low SHALL immediately force state=IDLE, sq=0, accumulator=0, counter=0 and operand registers=0, so that in_ready=1 and out_valid=0.
REQ-024 Reset asserted during CALC or DONE SHALL discard the in-flight result; after release, the first edge with in_valid=1 SHALL start a fresh operation.
REQ-025 Reset release SHALL be synchronised externally; the block SHALL have no internal reset synchroniser.

Structure
REQ-026 State encodings and the counter-width function SHALL live in the shared include file isquare_defs.vh, with counter width = ceil(log2(WIDTH+1)).
REQ-027 The operand-magnitude logic (REQ-014) SHALL be a sub-module isquare_mag (WIDTH, TC_MODE); all remaining logic SHALL be in isquare_seq.
REQ-028 The block SHALL use no vendor multiplier primitives or operators; it SHALL use only add, shift and compare.

Verification
REQ-029 WIDTH=4, TC_MODE=0: accept x=4'hF with out_ready=1 held -> out_valid high exactly 4 edges after accept with sq=8'hE1, and in_ready high on the following cycle.
REQ-030 WIDTH=4, TC_MODE=1: x=4'b1000 (-8) -> sq=8'h40; x=4'b1101 (-3) -> sq=8'h09.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles after completion of x=4'd7 -> sq=8'h31 stable and out_valid=1 throughout; a new in_valid during this time is not accepted (in_ready=0).
REQ-032 Assert reset_n=0 for one cycle on the 2nd CALC edge of x=4'd9 -> sq=0 and out_valid=0 immediately; next x=4'd2 -> sq=8'h04 after 4 edges.
REQ-033 Exhaustive WIDTH=4, TC_MODE=0 round-trip: for every x in 0..15, sq = x*x, and the existing integer square-root block (width=8, tc_mode=0) applied to sq returns x.
REQ-034 Back-to-back stream with in_valid and out_ready tied high -> one result per WIDTH+2 cycles, with no lost or duplicated operands.

Source files
------------

// File: rtl/isquare_pkg.sv
// Shared definitions for the shift-add squarer: FSM state encoding and the
// iteration-counter width helper.
package isquare_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must be able to hold WIDTH, hence ceil(log2(WIDTH+1)).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/isquare_mag.sv
// Operand magnitude: pass-through when unsigned, two's-complement negate of
// negative values when TC_MODE=1 (most negative input maps to 2^(WIDTH-1)).
module isquare_mag #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TC_MODE = 0
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] mag_o
);

  always_comb begin
    mag_o = x_i;
    if ((TC_MODE != 0) && x_i[WIDTH-1]) begin
      mag_o = ~x_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/isquare_seq.sv
// Sequential squarer: one shift-add step per cycle over WIDTH cycles, with a
// valid/ready handshake on both the operand and result sides.
module isquare_seq
  import isquare_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TC_MODE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   x,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] sq,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   sq_q, sq_d;
  logic [WIDTH-1:0]     mag;
  logic [2*WIDTH-1:0]   acc_sum;

  isquare_mag #(
    .WIDTH  (WIDTH),
    .TC_MODE(TC_MODE)
  ) u_mag (
    .x_i  (x),
    .mag_o(mag)
  );

  // Accumulator value after this cycle's step, including the final addition.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag};
          mplier_d = mag;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sq_d    = acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sq_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sq        = sq_q;

endmodule

// File: tb/tb_isquare_seq.sv
// Self-checking bench for isquare_seq: an unsigned and a two's-complement
// instance driven in lockstep, with a queue of expected squares.
module tb_isquare_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] x = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready_u, out_valid_u, in_ready_t, out_valid_t;
  logic [7:0] sq_u, sq_t;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isquare_seq #(.WIDTH(4), .TC_MODE(0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .x        (x),
    .in_valid (in_valid),
    .in_ready (in_ready_u),
    .sq       (sq_u),
    .out_valid(out_valid_u),
    .out_ready(out_ready)
  );

  isquare_seq #(.WIDTH(4), .TC_MODE(1)) dut_tc (
    .clk      (clk),
    .reset_n  (reset_n),
    .x        (x),
    .in_valid (in_valid),
    .in_ready (in_ready_t),
    .sq       (sq_t),
    .out_valid(out_valid_t),
    .out_ready(out_ready)
  );

  function automatic logic [7:0] model_sq(input logic [3:0] xv, input bit tc);
    int m;
    m = (tc && xv[3]) ? (16 - int'(xv)) : int'(xv);
    return 8'(m * m);
  endfunction

  // Waits for out_valid on the chosen instance; lat counts edges after accept.
  task automatic wait_done(input bit tc, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((tc ? out_valid_t : out_valid_u) === 1'b1) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] xv, input bit tc, output logic [7:0] got);
    int lat;
    bit ok;
    logic [7:0] e;
    exp_q.push_back(model_sq(xv, tc));
    checks++;
    if ((tc ? in_ready_t : in_ready_u) !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready x=%0h got=%b exp=1", xv, tc ? in_ready_t : in_ready_u);
    end
    x = xv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(tc, lat, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout x=%0h got=no_out_valid exp=out_valid", xv);
    end else if (lat !== 4) begin
      failures++;
      $display("FAIL latency x=%0h got=%0d exp=4", xv, lat);
    end
    got = tc ? sq_t : sq_u;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL square x=%0h tc=%0d got=%0h exp=%0h", xv, tc, got, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({(tc ? in_ready_t : in_ready_u), (tc ? out_valid_t : out_valid_u)} !== 2'b10) begin
      failures++;
      $display("FAIL back_to_idle x=%0h got=%b%b exp=10", xv,
               tc ? in_ready_t : in_ready_u, tc ? out_valid_t : out_valid_u);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({in_ready_u, out_valid_u, sq_u} !== {1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got=%b/%b/%0h exp=1/0/0", in_ready_u, out_valid_u, sq_u);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max_held_ready();
    int lat;
    bit ok;
    logic [7:0] e;
    exp_q.push_back(model_sq(4'hF, 1'b0));
    x = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(1'b0, lat, ok);
    checks++;
    if (!ok || lat !== 4) begin
      failures++;
      $display("FAIL max_latency got=%0d exp=4", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (sq_u !== e || sq_u !== 8'hE1) begin
      failures++;
      $display("FAIL max_square got=%0h exp=%0h", sq_u, e);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready_u !== 1'b1) begin
      failures++;
      $display("FAIL max_ready_after got=%b exp=1", in_ready_u);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_tc();
    logic [7:0] got;
    run_op(4'b1000, 1'b1, got);
    checks++;
    if (got !== 8'h40) begin
      failures++;
      $display("FAIL tc_minus8 got=%0h exp=40", got);
    end
    run_op(4'b1101, 1'b1, got);
    checks++;
    if (got !== 8'h09) begin
      failures++;
      $display("FAIL tc_minus3 got=%0h exp=09", got);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [7:0] e;
    exp_q.push_back(model_sq(4'd7, 1'b0));
    x = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(1'b0, lat, ok);
    e = exp_q.pop_front();
    x = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid_u, in_ready_u, sq_u} !== {1'b1, 1'b0, e}) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%b/%b/%0h exp=1/0/%0h", i, out_valid_u,
                 in_ready_u, sq_u, e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready_u, out_valid_u, sq_u} !== {1'b1, 1'b0, 8'h31}) begin
      failures++;
      $display("FAIL idle_retain got=%b/%b/%0h exp=1/0/31", in_ready_u, out_valid_u, sq_u);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [7:0] got;
    exp_q.push_back(model_sq(4'd9, 1'b0));
    x = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({sq_u, out_valid_u, in_ready_u} !== {8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got=%0h/%b/%b exp=0/0/1", sq_u, out_valid_u, in_ready_u);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(4'd2, 1'b0, got);
  endtask

  task automatic test_exhaustive();
    logic [7:0] got;
    int r;
    for (int xv = 0; xv < 16; xv++) begin
      run_op(4'(xv), 1'b0, got);
      r = 0;
      while ((r + 1) * (r + 1) <= int'(got)) r++;
      checks++;
      if (r !== xv) begin
        failures++;
        $display("FAIL isqrt_roundtrip x=%0d got=%0d exp=%0d", xv, r, xv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [6] = '{4'd5, 4'd0, 4'd15, 4'd1, 4'd12, 4'd6};
    int lat, prev, now;
    bit ok;
    logic [7:0] e;
    prev = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    x = vals[0];
    exp_q.push_back(model_sq(vals[0], 1'b0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      wait_done(1'b0, lat, ok);
      now = cyc;
      e = exp_q.pop_front();
      checks++;
      if (!ok || sq_u !== e) begin
        failures++;
        $display("FAIL b2b_square k=%0d got=%0h exp=%0h", k, sq_u, e);
      end
      if (k > 0) begin
        checks++;
        if (now - prev !== 6) begin
          failures++;
          $display("FAIL b2b_interval k=%0d got=%0d exp=6", k, now - prev);
        end
      end
      prev = now;
      if (k < 5) begin
        x = vals[k+1];
        exp_q.push_back(model_sq(vals[k+1], 1'b0));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() !== 0 || in_ready_u !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain got=%0d/%b exp=0/1", exp_q.size(), in_ready_u);
    end
  endtask

  initial begin
    test_reset();
    test_max_held_ready();
    test_tc();
    test_backpressure();
    test_reset_mid_calc();
    test_exhaustive();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
